// File: rtl/input_parser_ctrl_pkg.sv
// Shared definitions for the input_parser sequencer.
// Contents: controller state enum, default lane/array geometry, default skew
// latency and a helper that gives the packed width of one row vector.
package input_parser_ctrl_pkg;

    // Bits per lane element (lane-slice width) and array edge length defaults.
    localparam int unsigned LaneW       = 16;
    localparam int unsigned DefFullSize = 8;
    // Skew stage needs 2*FULL_SIZE cycles before the last lane of a beat leaves.
    localparam int unsigned DefSkewLat  = 2 * DefFullSize;

    typedef enum logic [1:0] {
        StFlush,
        StIdle,
        StFeed,
        StDrain
    } ipc_state_e;

    function automatic int unsigned vec_w(input int unsigned lanes, input int unsigned lane_w);
        return lanes * lane_w;
    endfunction

endpackage

// File: rtl/ipc_valid_delay.sv
// Fixed-depth 1-bit shift line carrying the beat-head marker beside the skew pipeline.
// Ports:
//   clk_i   clock, rising edge
//   clr_i   synchronous clear of every stage
//   din_i   marker entering the line
//   dout_o  marker leaving the line, Depth cycles after entry (registered)
module ipc_valid_delay #(
    parameter int unsigned Depth = 16
) (
    input  logic clk_i,
    input  logic clr_i,
    input  logic din_i,
    output logic dout_o
);

    logic [Depth-1:0] sr_q;

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            sr_q <= '0;
        end else begin
            sr_q <= {sr_q[Depth-2:0], din_i};
        end
    end

    assign dout_o = sr_q[Depth-1];

endmodule

// File: rtl/input_parser_ctrl.sv
// Sequencer feeding row vectors into the input_parser skew stage.
// Flushes the (unreset) parser after reset, accepts a job (tile mode, row count),
// streams beats with zero bubbles on source stalls, then drains with zeros.
// Ports:
//   clk, rst_n            clock and synchronous active-low reset
//   cfg_valid/cfg_ready   job handshake; cfg_tile, cfg_rows job fields
//   s_valid/s_ready       row beat handshake; s_data_0, s_data_1 row streams
//   p_enable, p_tile      parser enable and tile select
//   p_in_0, p_in_1        parser inputs (zero when no beat is presented)
//   o_valid               parser output carries a beat head this cycle
//   busy, done            not idle; one-cycle job-completion pulse
//   bubble_cnt            FEED stall-cycle count (only with IPC_BUBBLE_CNT_EN)
// Optional feature macro: IPC_BUBBLE_CNT_EN.
module input_parser_ctrl
    import input_parser_ctrl_pkg::*;
#(
    parameter int unsigned FULL_SIZE  = DefFullSize,
    parameter int unsigned HALF_SIZE  = DefFullSize / 2,
    parameter int unsigned DATA_WIDTH = LaneW,
    parameter int unsigned SKEW_LAT   = DefSkewLat,
    parameter int unsigned ROW_W      = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                cfg_valid,
    output logic                                cfg_ready,
    input  logic                                cfg_tile,
    input  logic [ROW_W-1:0]                    cfg_rows,
    input  logic                                s_valid,
    output logic                                s_ready,
    input  logic [vec_w(FULL_SIZE, DATA_WIDTH)-1:0] s_data_0,
    input  logic [vec_w(FULL_SIZE, DATA_WIDTH)-1:0] s_data_1,
    output logic                                p_enable,
    output logic                                p_tile,
    output logic [vec_w(FULL_SIZE, DATA_WIDTH)-1:0] p_in_0,
    output logic [vec_w(FULL_SIZE, DATA_WIDTH)-1:0] p_in_1,
    output logic                                o_valid,
    output logic                                busy,
    output logic                                done
`ifdef IPC_BUBBLE_CNT_EN
    ,
    output logic [15:0]                         bubble_cnt
`endif
);

    localparam int unsigned CntW = $clog2(SKEW_LAT);

    if (SKEW_LAT < 2 * FULL_SIZE || 2 * HALF_SIZE != FULL_SIZE) begin : g_bad_cfg
        $error("input_parser_ctrl: inconsistent FULL_SIZE/HALF_SIZE/SKEW_LAT");
    end

    ipc_state_e       state_q;
    logic [CntW-1:0]  cnt_q;
    logic [ROW_W-1:0] rows_q;
    logic [ROW_W-1:0] beat_q;
    // Marker registered alongside p_in so it enters the delay line with the beat.
    logic             mark_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StFlush;
            cnt_q     <= '0;
            rows_q    <= '0;
            beat_q    <= '0;
            mark_q    <= 1'b0;
            p_tile    <= 1'b0;
            p_in_0    <= '0;
            p_in_1    <= '0;
            p_enable  <= 1'b1;
            cfg_ready <= 1'b0;
            s_ready   <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
`ifdef IPC_BUBBLE_CNT_EN
            bubble_cnt <= '0;
`endif
        end else begin
            done   <= 1'b0;
            mark_q <= 1'b0;
            p_in_0 <= '0;
            p_in_1 <= '0;
            case (state_q)
                StFlush: begin
                    if (cnt_q == CntW'(SKEW_LAT - 1)) begin
                        state_q   <= StIdle;
                        cnt_q     <= '0;
                        cfg_ready <= 1'b1;
                        p_enable  <= 1'b0;
                        busy      <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StIdle: begin
                    if (cfg_valid && cfg_ready) begin
                        // Pipeline is empty here, so the tile mode may change now.
                        rows_q <= cfg_rows;
                        p_tile <= cfg_tile;
                        beat_q <= '0;
`ifdef IPC_BUBBLE_CNT_EN
                        bubble_cnt <= '0;
`endif
                        if (cfg_rows == '0) begin
                            done <= 1'b1;
                        end else begin
                            state_q   <= StFeed;
                            cfg_ready <= 1'b0;
                            s_ready   <= 1'b1;
                            p_enable  <= 1'b1;
                            busy      <= 1'b1;
                        end
                    end
                end
                StFeed: begin
                    if (s_valid && s_ready) begin
                        p_in_0 <= s_data_0;
                        p_in_1 <= p_tile ? s_data_1 : '0;
                        mark_q <= 1'b1;
                        beat_q <= beat_q + ROW_W'(1);
                        if (beat_q + ROW_W'(1) == rows_q) begin
                            state_q <= StDrain;
                            s_ready <= 1'b0;
                            cnt_q   <= '0;
                        end
                    end else begin
`ifdef IPC_BUBBLE_CNT_EN
                        if (bubble_cnt != 16'hFFFF) begin
                            bubble_cnt <= bubble_cnt + 16'd1;
                        end
`endif
                    end
                end
                StDrain: begin
                    if (cnt_q == CntW'(SKEW_LAT - 1)) begin
                        state_q   <= StIdle;
                        cnt_q     <= '0;
                        cfg_ready <= 1'b1;
                        p_enable  <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                default: begin
                    state_q <= StFlush;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    ipc_valid_delay #(
        .Depth(SKEW_LAT)
    ) u_valid_delay (
        .clk_i (clk),
        .clr_i (!rst_n),
        .din_i (mark_q),
        .dout_o(o_valid)
    );

endmodule

// File: tb/tb_input_parser_ctrl.sv
// Self-checking bench for input_parser_ctrl: timestamp-based reference model
// compared every cycle, directed scenarios with literal expectations, then
// randomized traffic including occasional resets.
module tb_input_parser_ctrl;

    localparam int unsigned FS = 8;
    localparam int unsigned HS = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned SL = 16;
    localparam int unsigned RW = 8;
    localparam int unsigned VW = FS * DW;
    localparam int unsigned NSLOT = 16384;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic          cfg_tile = 1'b0;
    logic [RW-1:0] cfg_rows = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [VW-1:0] s_data_0 = '0;
    logic [VW-1:0] s_data_1 = '0;
    logic          p_enable;
    logic          p_tile;
    logic [VW-1:0] p_in_0;
    logic [VW-1:0] p_in_1;
    logic          o_valid;
    logic          busy;
    logic          done;
`ifdef IPC_BUBBLE_CNT_EN
    logic [15:0]   bubble_cnt;
`endif

    input_parser_ctrl #(
        .FULL_SIZE (FS),
        .HALF_SIZE (HS),
        .DATA_WIDTH(DW),
        .SKEW_LAT  (SL),
        .ROW_W     (RW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_tile (cfg_tile),
        .cfg_rows (cfg_rows),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data_0 (s_data_0),
        .s_data_1 (s_data_1),
        .p_enable (p_enable),
        .p_tile   (p_tile),
        .p_in_0   (p_in_0),
        .p_in_1   (p_in_1),
        .o_valid  (o_valid),
        .busy     (busy),
        .done     (done)
`ifdef IPC_BUBBLE_CNT_EN
        ,
        .bubble_cnt(bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40) begin
                $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
            end
        end
    endtask

    // Reference model: events are scheduled by absolute edge number.
    bit            ov_at   [NSLOT];
    bit            done_at [NSLOT];
    bit            feeding = 1'b0;
    int            remaining = 0;
    int            idle_from = 0;
    logic          e_ready = 1'b0;
    logic          e_sready = 1'b0;
    logic          e_ptile = 1'b0;
    logic          e_ov = 1'b0;
    logic          e_done = 1'b0;
    logic [VW-1:0] e_pin0 = '0;
    logic [VW-1:0] e_pin1 = '0;
    logic [15:0]   e_bub = '0;

    initial begin : model_and_compare
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                feeding   = 1'b0;
                remaining = 0;
                idle_from = cyc + SL;
                for (int i = 0; i <= SL + 1; i++) begin
                    ov_at[cyc + i]   = 1'b0;
                    done_at[cyc + i] = 1'b0;
                end
                e_ptile  = 1'b0;
                e_bub    = '0;
                e_pin0   = '0;
                e_pin1   = '0;
                e_sready = 1'b0;
                e_ready  = 1'b0;
            end else begin
                e_pin0 = '0;
                e_pin1 = '0;
                if (e_ready && cfg_valid) begin
                    e_ptile = cfg_tile;
                    e_bub   = '0;
                    if (cfg_rows == 0) begin
                        done_at[cyc] = 1'b1;
                    end else begin
                        feeding   = 1'b1;
                        remaining = int'(cfg_rows);
                    end
                end else if (e_sready) begin
                    if (s_valid) begin
                        e_pin0 = s_data_0;
                        e_pin1 = e_ptile ? s_data_1 : '0;
                        ov_at[cyc + SL] = 1'b1;
                        remaining--;
                        if (remaining == 0) begin
                            feeding = 1'b0;
                            idle_from = cyc + SL;
                            done_at[cyc + SL] = 1'b1;
                        end
                    end else if (e_bub != 16'hFFFF) begin
                        e_bub = e_bub + 16'd1;
                    end
                end
                e_sready = feeding;
                e_ready  = !feeding && (cyc >= idle_from);
            end
            e_ov   = ov_at[cyc];
            e_done = done_at[cyc];
            #1;
            check("cfg_ready", 64'(cfg_ready), 64'(e_ready));
            check("s_ready",   64'(s_ready),   64'(e_sready));
            check("busy",      64'(busy),      64'(!e_ready));
            check("p_enable",  64'(p_enable),  64'(!e_ready));
            check("p_tile",    64'(p_tile),    64'(e_ptile));
            check("p_in_0",    64'(p_in_0),    64'(e_pin0));
            check("p_in_1",    64'(p_in_1),    64'(e_pin1));
            check("o_valid",   64'(o_valid),   64'(e_ov));
            check("done",      64'(done),      64'(e_done));
`ifdef IPC_BUBBLE_CNT_EN
            check("bubble_cnt", 64'(bubble_cnt), 64'(e_bub));
`endif
        end
    end

    task automatic wait_ready(input int max_cyc);
        int n = 0;
        while (!cfg_ready && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check("cfg_ready_wait", 64'(cfg_ready), 64'd1);
    endtask

    // Observation index r sees the outputs r edges after the cfg accept edge.
    task automatic run_job(input logic tile, input int rows, input int gap_at, input int gap_len,
                           input logic [VW-1:0] d0, input logic [VW-1:0] d1,
                           output logic [63:0] ov_mask, output logic [63:0] done_mask,
                           output logic [VW-1:0] pin0_r1, output logic [VW-1:0] pin1_r1,
                           output logic tile_r0);
        wait_ready(100);
        cfg_valid = 1'b1;
        cfg_tile  = tile;
        cfg_rows  = RW'(rows);
        s_valid   = 1'b0;
        ov_mask   = '0;
        done_mask = '0;
        pin0_r1   = '0;
        pin1_r1   = '0;
        tile_r0   = 1'b0;
        for (int r = 0; r < 48; r++) begin
            @(negedge clk);
            cfg_valid = 1'b0;
            if (o_valid) ov_mask[r] = 1'b1;
            if (done) done_mask[r] = 1'b1;
            if (r == 0) tile_r0 = p_tile;
            if (r == 1) begin
                pin0_r1 = p_in_0;
                pin1_r1 = p_in_1;
            end
            s_valid = 1'b0;
            for (int k = 0; k < rows; k++) begin
                if (k + ((k >= gap_at) ? gap_len : 0) == r) begin
                    s_valid  = 1'b1;
                    s_data_0 = d0 + VW'(k);
                    s_data_1 = d1 + VW'(k);
                end
            end
        end
        s_valid = 1'b0;
    endtask

    initial begin : stimulus
        logic [63:0] ovm, dnm;
        logic [VW-1:0] p0, p1;
        logic t0;
        int n;
        logic any_pin, seen_done;
        logic [VW-1:0] lanes0;
        logic [VW-1:0] lanes1;
        lanes0 = 64'h0807_0605_0403_0201;
        lanes1 = 64'h8877_6655_4433_2211;

        // Reset, then count observations until cfg_ready rises.
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        any_pin = 1'b0;
        while (!cfg_ready && n < 100) begin
            any_pin = any_pin | (|p_in_0) | (|p_in_1);
            @(negedge clk);
            n++;
        end
        check("flush_len", 64'(n), 64'd16);
        check("flush_pin_zero", 64'(any_pin), 64'd0);

        // tile=0, two back-to-back beats.
        run_job(1'b0, 2, 99, 0, lanes0, lanes1, ovm, dnm, p0, p1, t0);
        check("j1_ov_mask", ovm, 64'h0000_0000_0006_0000);
        check("j1_done_mask", dnm, 64'h0000_0000_0004_0000);
        check("j1_pin0", 64'(p0), 64'h0807_0605_0403_0201);
        check("j1_pin1", 64'(p1), 64'd0);
        check("j1_tile", 64'(t0), 64'd0);

        // tile=1 then tile=0 back-to-back.
        run_job(1'b1, 2, 99, 0, lanes0, lanes1, ovm, dnm, p0, p1, t0);
        check("j2_tile", 64'(t0), 64'd1);
        check("j2_pin1", 64'(p1), 64'h8877_6655_4433_2211);
        check("j2_ov_mask", ovm, 64'h0000_0000_0006_0000);
        check("j2_done_mask", dnm, 64'h0000_0000_0004_0000);
        run_job(1'b0, 2, 99, 0, lanes0, lanes1, ovm, dnm, p0, p1, t0);
        check("j3_tile", 64'(t0), 64'd0);
        check("j3_ov_mask", ovm, 64'h0000_0000_0006_0000);

        // rows=3 with a 2-cycle stall after the first beat.
        run_job(1'b0, 3, 1, 2, lanes0, lanes1, ovm, dnm, p0, p1, t0);
        check("j4_ov_mask", ovm, 64'h0000_0000_0032_0000);
        check("j4_done_mask", dnm, 64'h0000_0000_0020_0000);
`ifdef IPC_BUBBLE_CNT_EN
        check("j4_bubble_cnt", 64'(bubble_cnt), 64'd2);
`endif

        // rows=0: immediate done, no o_valid.
        run_job(1'b1, 0, 99, 0, lanes0, lanes1, ovm, dnm, p0, p1, t0);
        check("j5_ov_mask", ovm, 64'd0);
        check("j5_done_mask", dnm, 64'd1);

        // Reset during FEED aborts the job and re-runs the flush.
        wait_ready(100);
        cfg_valid = 1'b1;
        cfg_tile  = 1'b0;
        cfg_rows  = RW'(5);
        @(negedge clk);
        cfg_valid = 1'b0;
        s_valid   = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        s_valid = 1'b0;
        n = 0;
        seen_done = 1'b0;
        while (!cfg_ready && n < 100) begin
            seen_done = seen_done | done;
            @(negedge clk);
            n++;
        end
        check("rst_flush_len", 64'(n), 64'd16);
        check("rst_no_done", 64'(seen_done), 64'd0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst_n     = ($urandom_range(0, 499) != 0);
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_tile  = 1'($urandom_range(0, 1));
            cfg_rows  = ($urandom_range(0, 7) == 0) ? RW'(0) : RW'($urandom_range(1, 12));
            s_valid   = ($urandom_range(0, 9) < 7);
            s_data_0  = {$urandom, $urandom};
            s_data_1  = {$urandom, $urandom};
        end
        @(negedge clk);
        rst_n     = 1'b1;
        cfg_valid = 1'b0;
        s_valid   = 1'b0;
        repeat (60) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
